sifive_regfile_shadow_tap: RTL and testbench
============================================

// Module: sifive_regfile_shadow_tap
// PURPOSE
//  Parametrised successor to the fixed 31x32 integer-regfile tap. Mirrors core
//  regfile writeback into a shadow array and exposes it as a flat live bus.
//  Adds freeze/snapshot capture, per-register dirty tracking and a valid/ready
//  dump stream. Lets the scope unit read a coherent regfile image without
//  hierarchical references. Sits beside the core, fed by its writeback port.
// PARAMETERS
//  XLEN        32  data width of one register
//  NREGS       31  shadowed registers; arch regs x1..xNREGS; x0 never stored
//  ADDR_W      5   width of wb_addr; must satisfy 2**ADDR_W > NREGS
//  DIRTY_ONLY  0   1: dump emits only entries whose captured dirty bit is set
// PORTS
//  clock       in   1            block clock
//  reset       in   1            synchronous, active-high reset
//  wb_valid    in   1            regfile write this cycle
//  wb_addr     in   ADDR_W       arch register index written
//  wb_data     in   XLEN         write data
//  freeze      in   1            capture snapshot; honoured in TRACK only
//  thaw        in   1            release snapshot; honoured in FROZEN only
//  dump_start  in   1            begin streaming snapshot; honoured in FROZEN only
//  dump_ready  in   1            sink accepts current beat
//  dump_valid  out  1            beat valid
//  dump_idx    out  ADDR_W       arch index (1..NREGS) of the beat
//  dump_data   out  XLEN         snapshot value of that register
//  dump_last   out  1            final beat of this dump
//  dump_done   out  1            one-cycle pulse once the dump completes
//  frozen      out  1            state != TRACK
//  live_mem    out  NREGS*XLEN   live shadow; slice i = arch reg x(i+1)
//  dirty_live  out  NREGS        regs written since last freeze
// BEHAVIOUR
//  Reset:
//   - shadow, snapshot, dirty_live and captured dirty mask all zero
//   - state TRACK; dump_valid/dump_last/dump_done/frozen = 0
//   - dump_idx = 0, dump_data = 0
//  Shadow write:
//   - wb_valid with 1<=wb_addr<=NREGS updates slice wb_addr-1 next cycle
//   - same write sets dirty_live[wb_addr-1]; done in every state
//   - wb_addr 0 or >NREGS is ignored
//   - live_mem reflects the write one cycle after wb_valid
//  Freeze (TRACK -> FROZEN), on freeze:
//   - snapshot <= shadow, merged with any same-cycle legal write
//   - captured mask <= dirty_live | same-cycle write bit; dirty_live <= 0
//   - a same-cycle write sets no bit in the new dirty_live
//   - freeze in any other state is ignored
//  FROZEN:
//   - snapshot and mask hold; shadow keeps tracking
//   - thaw -> TRACK; dump_start -> DUMP; both together: dump_start wins
//  DUMP:
//   - dump_valid rises the cycle after dump_start, at the lowest eligible index
//   - eligible = every index if DIRTY_ONLY=0, else only captured-dirty indices
//   - beats ascend; index advances only on dump_valid & dump_ready
//   - dump_valid, dump_idx, dump_data, dump_last hold stable while stalled
//   - no bubbles between eligible beats when dump_ready is held high
//   - dump_last marks the highest eligible index
//   - after the last handshake: dump_valid=0, dump_done pulses next cycle
//   - state then returns to FROZEN; snapshot is retained for re-dump
//   - DIRTY_ONLY with empty mask: no beats; dump_done pulses the cycle after
//     dump_start
//   - freeze and thaw are ignored during DUMP
//  Reset in any state, including mid-DUMP: every reset value above applies on
//   the next edge; no partial beat survives.
// TESTING
//  - reset; write x5=0xDEADBEEF -> next cycle live_mem[4*32+:32]=0xDEADBEEF,
//    dirty_live=0x10
//  - write x0 and x31 with NREGS=30 -> live_mem and dirty_live unchanged
//  - freeze with same-cycle write x1=0x11 -> snapshot x1=0x11, dirty_live=0;
//    next write x1=0x22 leaves the dump value at 0x11
//  - DIRTY_ONLY=0 dump, ready toggling every cycle -> 31 beats idx 1..31,
//    data stable when stalled, last on idx 31, done one cycle after
//  - DIRTY_ONLY=1, mask {x3,x7} -> two beats (3 then 7, last on 7);
//    empty mask -> no dump_valid, done the cycle after dump_start
//  - reset asserted at beat 10 of a dump -> next cycle dump_valid=0, frozen=0,
//    live_mem=0

Source files
------------

// File: rtl/sifive_regfile_shadow_tap.sv
// Shadow copy of the core integer regfile with freeze/snapshot capture,
// per-register dirty tracking and a valid/ready dump stream of the snapshot.
module sifive_regfile_shadow_tap #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 31,
  parameter int ADDR_W     = 5,
  parameter bit DIRTY_ONLY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  freeze,
  input  logic                  thaw,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [ADDR_W-1:0]     dump_idx,
  output logic [XLEN-1:0]       dump_data,
  output logic                  dump_last,
  output logic                  dump_done,
  output logic                  frozen,
  output logic [NREGS*XLEN-1:0] live_mem,
  output logic [NREGS-1:0]      dirty_live,
  output logic [1:0]            dbg_state
);

  // Dump handshake: a beat transfers on a cycle where dump_valid and dump_ready
  // are both high; once raised, dump_valid/idx/data/last hold until that cycle.

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    FROZEN = 2'd1,
    DUMP   = 2'd2
  } state_e;

  state_e                      state_q;
  logic [NREGS-1:0][XLEN-1:0]  shadow_q, shadow_d;
  logic [NREGS-1:0][XLEN-1:0]  snap_q;
  logic [NREGS-1:0]            dirty_q, mask_q;
  logic [NREGS-1:0]            wr_bit;
  logic [NREGS-1:0]            elig;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_pos;
  logic [ADDR_W-1:0]           pos_q;
  logic                        valid_q, last_q, done_q;
  logic [ADDR_W-1:0]           idx_q;
  logic [XLEN-1:0]             data_q;
  int                          srch_from;
  logic                        nxt_found;
  logic [ADDR_W-1:0]           nxt_pos;
  logic                        nxt_last;

  function automatic logic [ADDR_W-1:0] first_pos(input logic [NREGS-1:0] e, input int from);
    logic [ADDR_W-1:0] p;
    p = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (e[i] && i >= from) p = ADDR_W'(i);
    return p;
  endfunction

  function automatic logic any_from(input logic [NREGS-1:0] e, input int from);
    logic f;
    f = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (e[i] && i >= from) f = 1'b1;
    return f;
  endfunction

  always_comb begin
    wr_en    = wb_valid && (wb_addr != '0) && (wb_addr <= ADDR_W'(NREGS));
    wr_pos   = wb_addr - ADDR_W'(1);
    wr_bit   = '0;
    shadow_d = shadow_q;
    if (wr_en) begin
      wr_bit[wr_pos]   = 1'b1;
      shadow_d[wr_pos] = wb_data;
    end
  end

  // From FROZEN the search starts at the bottom; in DUMP it starts just above
  // the beat currently presented.
  always_comb begin
    elig      = DIRTY_ONLY ? mask_q : '1;
    srch_from = (state_q == DUMP) ? int'(pos_q) + 1 : 0;
    nxt_found = any_from(elig, srch_from);
    nxt_pos   = first_pos(elig, srch_from);
    nxt_last  = !any_from(elig, int'(nxt_pos) + 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= TRACK;
      shadow_q <= '0;
      snap_q   <= '0;
      dirty_q  <= '0;
      mask_q   <= '0;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_q | wr_bit;
      done_q   <= 1'b0;
      case (state_q)
        TRACK: begin
          if (freeze) begin
            snap_q  <= shadow_d;
            mask_q  <= dirty_q | wr_bit;
            dirty_q <= '0;
            state_q <= FROZEN;
          end
        end
        FROZEN: begin
          if (dump_start) begin
            if (nxt_found) begin
              valid_q <= 1'b1;
              pos_q   <= nxt_pos;
              idx_q   <= nxt_pos + ADDR_W'(1);
              data_q  <= snap_q[nxt_pos];
              last_q  <= nxt_last;
              state_q <= DUMP;
            end else begin
              done_q  <= 1'b1;
            end
          end else if (thaw) begin
            state_q <= TRACK;
          end
        end
        DUMP: begin
          if (valid_q && dump_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FROZEN;
            end else begin
              pos_q  <= nxt_pos;
              idx_q  <= nxt_pos + ADDR_W'(1);
              data_q <= snap_q[nxt_pos];
              last_q <= nxt_last;
            end
          end
        end
        default: state_q <= TRACK;
      endcase
    end
  end

  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign dump_last  = last_q;
  assign dump_done  = done_q;
  assign frozen     = (state_q != TRACK);
  assign live_mem   = shadow_q;
  assign dirty_live = dirty_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sifive_regfile_shadow_tap.sv
// Directed bench: instance a uses the default 31x32 full dump, instance b uses
// NREGS=30 with DIRTY_ONLY=1.
module tb_sifive_regfile_shadow_tap;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance a
  logic          a_wb_valid = 0, a_freeze = 0, a_thaw = 0, a_dump_start = 0, a_dump_ready = 0;
  logic [4:0]    a_wb_addr = 0;
  logic [31:0]   a_wb_data = 0;
  logic          a_valid, a_last, a_done, a_frozen;
  logic [4:0]    a_idx;
  logic [31:0]   a_data;
  logic [991:0]  a_live;
  logic [30:0]   a_dirty;
  logic [1:0]    a_state;

  // instance b
  logic          b_wb_valid = 0, b_freeze = 0, b_thaw = 0, b_dump_start = 0, b_dump_ready = 0;
  logic [4:0]    b_wb_addr = 0;
  logic [31:0]   b_wb_data = 0;
  logic          b_valid, b_last, b_done, b_frozen;
  logic [4:0]    b_idx;
  logic [31:0]   b_data;
  logic [959:0]  b_live;
  logic [29:0]   b_dirty;
  logic [1:0]    b_state;

  sifive_regfile_shadow_tap u_a (
    .clock(clk), .reset(rst), .wb_valid(a_wb_valid), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
    .freeze(a_freeze), .thaw(a_thaw), .dump_start(a_dump_start), .dump_ready(a_dump_ready),
    .dump_valid(a_valid), .dump_idx(a_idx), .dump_data(a_data), .dump_last(a_last),
    .dump_done(a_done), .frozen(a_frozen), .live_mem(a_live), .dirty_live(a_dirty),
    .dbg_state(a_state)
  );

  sifive_regfile_shadow_tap #(.NREGS(30), .DIRTY_ONLY(1'b1)) u_b (
    .clock(clk), .reset(rst), .wb_valid(b_wb_valid), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .freeze(b_freeze), .thaw(b_thaw), .dump_start(b_dump_start), .dump_ready(b_dump_ready),
    .dump_valid(b_valid), .dump_idx(b_idx), .dump_data(b_data), .dump_last(b_last),
    .dump_done(b_done), .frozen(b_frozen), .live_mem(b_live), .dirty_live(b_dirty),
    .dbg_state(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] a_pat(input int i);
    return (i == 1) ? 32'h11 : (32'hA000_0000 | i);
  endfunction

  initial begin
    int  exp_idx;
    int  beats;
    bit  fin;
    bit  r;

    // reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", a_valid, 0);
    chk("rst_frozen", a_frozen, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_data", a_data, 0);
    chk("rst_done", a_done, 0);
    chk("rst_last", a_last, 0);
    chk("rst_live_zero", |a_live, 0);
    chk("rst_dirty", a_dirty, 0);

    // x5 write
    a_wb_valid = 1; a_wb_addr = 5; a_wb_data = 32'hDEADBEEF;
    tick();
    chk("x5_live", a_live[4*32 +: 32], 32'hDEADBEEF);
    chk("x5_dirty", a_dirty, 31'h10);

    // x0 write ignored
    a_wb_addr = 0; a_wb_data = 32'h1234;
    tick();
    a_wb_valid = 0;
    chk("x0_live0", a_live[0 +: 32], 0);
    chk("x0_live5", a_live[4*32 +: 32], 32'hDEADBEEF);
    chk("x0_dirty", a_dirty, 31'h10);

    // fill every register, x1 is rewritten together with freeze
    for (int i = 1; i <= 31; i++) begin
      a_wb_valid = 1; a_wb_addr = 5'(i); a_wb_data = 32'hA000_0000 | i;
      tick();
    end
    a_wb_addr = 1; a_wb_data = 32'h11; a_freeze = 1;
    tick();
    a_freeze = 0;
    chk("frz_frozen", a_frozen, 1);
    chk("frz_dirty", a_dirty, 0);
    chk("frz_live1", a_live[0 +: 32], 32'h11);
    a_wb_data = 32'h22;
    tick();
    a_wb_valid = 0;
    chk("post_live1", a_live[0 +: 32], 32'h22);
    chk("post_dirty", a_dirty, 31'h1);

    // full dump with ready toggling
    a_dump_start = 1;
    tick();
    a_dump_start = 0;
    chk("d1_state", a_state, 2'd2);
    exp_idx = 1; beats = 0; fin = 0; r = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      chk("d1_valid", a_valid, 1);
      chk("d1_idx", a_idx, exp_idx);
      chk("d1_data", a_data, a_pat(exp_idx));
      chk("d1_last", a_last, (exp_idx == 31));
      a_dump_ready = r;
      tick();
      if (r) begin
        beats++;
        if (exp_idx == 31) fin = 1;
        else exp_idx++;
      end
      r = ~r;
    end
    a_dump_ready = 0;
    chk("d1_finished", fin, 1);
    chk("d1_beats", beats, 31);
    chk("d1_end_valid", a_valid, 0);
    chk("d1_done", a_done, 1);
    tick();
    chk("d1_done_pulse", a_done, 0);
    chk("d1_frozen", a_frozen, 1);

    // re-dump of retained snapshot, no bubbles, reset at beat 10
    a_dump_start = 1; a_dump_ready = 1;
    tick();
    a_dump_start = 0;
    for (int k = 1; k <= 9; k++) begin
      chk("d2_valid", a_valid, 1);
      chk("d2_idx", a_idx, k);
      chk("d2_data", a_data, a_pat(k));
      tick();
    end
    chk("d2_idx10", a_idx, 10);
    chk("d2_data10", a_data, a_pat(10));
    rst = 1;
    tick();
    rst = 0; a_dump_ready = 0;
    chk("mrst_valid", a_valid, 0);
    chk("mrst_frozen", a_frozen, 0);
    chk("mrst_live_zero", |a_live, 0);
    chk("mrst_dirty", a_dirty, 0);
    chk("mrst_idx", a_idx, 0);
    chk("mrst_last", a_last, 0);

    // freeze / thaw round trip
    a_freeze = 1;
    tick();
    a_freeze = 0;
    chk("ft_frozen", a_frozen, 1);
    a_thaw = 1;
    tick();
    a_thaw = 0;
    chk("ft_thawed", a_frozen, 0);

    // instance b: out-of-range writes ignored
    b_wb_valid = 1; b_wb_addr = 31; b_wb_data = 32'hFFFF_FFFF;
    tick();
    b_wb_addr = 0;
    tick();
    chk("b_oob_live", |b_live, 0);
    chk("b_oob_dirty", b_dirty, 0);
    b_wb_addr = 3; b_wb_data = 32'h33;
    tick();
    b_wb_addr = 7; b_wb_data = 32'h77;
    tick();
    b_wb_valid = 0;
    chk("b_dirty37", b_dirty, 30'h44);
    b_freeze = 1;
    tick();
    b_freeze = 0;
    chk("b_frz_dirty", b_dirty, 0);
    b_wb_valid = 1; b_wb_addr = 4; b_wb_data = 32'h44;
    tick();
    b_wb_valid = 0;

    // dirty-only dump of {x3, x7}
    b_dump_start = 1; b_dump_ready = 1;
    tick();
    b_dump_start = 0;
    chk("b_b1_valid", b_valid, 1);
    chk("b_b1_idx", b_idx, 3);
    chk("b_b1_data", b_data, 32'h33);
    chk("b_b1_last", b_last, 0);
    tick();
    chk("b_b2_valid", b_valid, 1);
    chk("b_b2_idx", b_idx, 7);
    chk("b_b2_data", b_data, 32'h77);
    chk("b_b2_last", b_last, 1);
    tick();
    chk("b_end_valid", b_valid, 0);
    chk("b_end_done", b_done, 1);
    tick();
    b_dump_ready = 0;
    chk("b_end_pulse", b_done, 0);
    chk("b_end_frozen", b_frozen, 1);

    // empty mask: thaw/freeze twice so the second capture sees no writes
    b_thaw = 1; tick(); b_thaw = 0;
    b_freeze = 1; tick(); b_freeze = 0;
    b_thaw = 1; tick(); b_thaw = 0;
    b_freeze = 1; tick(); b_freeze = 0;
    b_dump_start = 1;
    tick();
    b_dump_start = 0;
    chk("b_empty_valid", b_valid, 0);
    chk("b_empty_done", b_done, 1);
    tick();
    chk("b_empty_pulse", b_done, 0);
    chk("b_empty_valid2", b_valid, 0);
    chk("b_empty_frozen", b_frozen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
